pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives enable/flush/hazard_stall of PC, IF_ID, ID_EX, EX_MEM, MEM_WB from cache stalls, load-use hazards, EX-stage branch redirects and multi-cycle MDU ops.
- Replaces scattered per-stage stall glue with one prioritised decision per cycle.
- Small FSM covers multi-cycle waits and redirects that overlap an outstanding I-cache fill.

Parameters:
MDU_MAX_CYCLES, 40, cycles in MDU_WAIT before mdu_timeout asserts
PERF_W, 32, width of performance counters (PIPE_CTRL_PERF_EN only)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
icache_stall  input  1  fetch not ready this cycle
dcache_stall  input  1  MEM access not complete this cycle
load_use_hazard  input  1  ID consumes rd of a load currently in EX
branch_taken  input  1  EX resolved taken branch/jump (redirect PC)
mdu_start  input  1  valid MUL/DIV entering execution in EX this cycle
mdu_done  input  1  MDU result valid this cycle
pc_en  output  1  PC register load enable
pc_redirect  output  1  PC mux selects EX branch target
if_id_en  output  1  IF_ID enable
if_id_flush  output  1  IF_ID bubble insert
id_ex_en  output  1  ID_EX enable
id_ex_flush  output  1  ID_EX flush
id_ex_hazard_stall  output  1  ID_EX bubble for load-use
ex_mem_en  output  1  EX_MEM enable
ex_mem_flush  output  1  EX_MEM bubble insert
mem_wb_en  output  1  MEM_WB enable
mdu_timeout  output  1  sticky: MDU exceeded MDU_MAX_CYCLES
stall_cycles  output  PERF_W  cycles with pc_en=0 (feature only)
flush_events  output  PERF_W  redirect count (feature only)

Behaviour:
- State register: RUN, MDU_WAIT, REDIRECT.
- Outputs are combinational from state and inputs. Default: all *_en=1, all flushes/stalls=0, pc_redirect=0.
- Reset (rst_n=0 at posedge): state=RUN, MDU counter=0, mdu_timeout=0, perf counters=0.
- While rst_n=0: all *_en=0, all flush/stall=0, pc_redirect=0.
- Priority each cycle, highest first:
  1. dcache_stall=1: all *_en=0, no flush, pc_redirect=0. State, MDU counter and inputs are ignored and held (global freeze, including branch_taken).
  2. State MDU_WAIT:
     - pc_en=if_id_en=id_ex_en=0; ex_mem_flush=1; mem_wb_en=1 (drain older instructions); counter++.
     - mdu_done=1: ex_mem_en=1, ex_mem_flush=0, all front enables=1, next state=RUN, counter=0.
     - Counter reaching MDU_MAX_CYCLES sets mdu_timeout (sticky until reset). Stay in MDU_WAIT.
  3. State RUN, branch_taken=1:
     - pc_redirect=1, pc_en=1, if_id_flush=1, id_ex_flush=1.
     - load_use_hazard ignored this cycle.
     - If icache_stall=1, next state=REDIRECT.
  4. State RUN, mdu_start=1 with mdu_done=0: pc_en=if_id_en=id_ex_en=0; ex_mem_flush=1; next state=MDU_WAIT. mdu_start with mdu_done in the same cycle is treated as a single-cycle op (stay RUN, default outputs).
  5. State RUN, load_use_hazard=1: pc_en=0, if_id_en=0, id_ex_hazard_stall=1 (exactly one bubble per assertion cycle).
  6. State RUN, icache_stall=1: pc_en=0, if_id_flush=1 (bubble into decode); back end keeps running.
- State REDIRECT (stale fill in flight):
  - if_id_flush=1 every cycle, including the cycle icache_stall falls (the stale line is discarded).
  - pc_en=0 while icache_stall=1.
  - When icache_stall=0: pc_en=1 and next state=RUN.
  - branch_taken is not expected here (ID_EX flushed). If asserted, it takes the RUN-branch action and state stays REDIRECT.
- Invariants:
  - id_ex_en and id_ex_flush may both be 1; flush wins in ID_EX.
  - mem_wb_en=0 only under dcache_stall or reset.
  - Latency: every control response occurs in the same cycle as its cause; the FSM adds no delay cycles.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: stall_cycles increments on every cycle with rst_n=1 and pc_en=0. flush_events increments on each cycle with pc_redirect=1. Both wrap at 2^PERF_W-1 -> 0.
- Undefined: both outputs constant 0; no counter flops synthesised.

Test Plan:
- Load-use: load_use_hazard=1 for 1 cycle in RUN -> pc_en=0, if_id_en=0, id_ex_hazard_stall=1 that cycle only; next cycle all defaults.
- Branch with I-cache miss: branch_taken=1 and icache_stall=1 at T0, icache_stall held 3 more cycles -> T0 pc_redirect=1, id_ex_flush=1; T1..T4 if_id_flush=1; pc_en=0 T1..T3, pc_en=1 at T4; RUN at T5.
- MDU 5-cycle divide: mdu_start at T0, mdu_done at T5 -> front enables 0 and ex_mem_flush=1 T0..T4; T5 all en=1; state RUN at T6; mdu_timeout=0.
- MDU timeout: MDU_MAX_CYCLES=4, mdu_done never -> mdu_timeout=1 after 4 MDU_WAIT cycles and stays 1; rst_n=0 clears it.
- D-cache freeze over branch: dcache_stall=1 with branch_taken=1 for 2 cycles -> all en=0, pc_redirect=0; on release the branch is serviced (pc_redirect=1).
- Reset mid-MDU_WAIT: rst_n=0 at T2 of a divide -> next cycle state RUN, counter 0, outputs default after rst_n=1; PERF build: stall_cycles=0 after reset, counts 3 for a 3-cycle icache_stall.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: one prioritised decision per cycle.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl #(
    parameter int MDU_MAX_CYCLES = 40,
    parameter int PERF_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_stall,
    input  logic              dcache_stall,
    input  logic              load_use_hazard,
    input  logic              branch_taken,
    input  logic              mdu_start,
    input  logic              mdu_done,
    output logic              pc_en,
    output logic              pc_redirect,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              id_ex_hazard_stall,
    output logic              ex_mem_en,
    output logic              ex_mem_flush,
    output logic              mem_wb_en,
    output logic              mdu_timeout,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
);

    localparam int CNT_W = $clog2(MDU_MAX_CYCLES + 1);

    typedef enum logic [1:0] {RUN, MDU_WAIT, REDIRECT} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] mdu_cnt;

    always_comb begin
        pc_en              = 1'b1;
        pc_redirect        = 1'b0;
        if_id_en           = 1'b1;
        if_id_flush        = 1'b0;
        id_ex_en           = 1'b1;
        id_ex_flush        = 1'b0;
        id_ex_hazard_stall = 1'b0;
        ex_mem_en          = 1'b1;
        ex_mem_flush       = 1'b0;
        mem_wb_en          = 1'b1;
        state_nxt          = state;

        if (!rst_n || dcache_stall) begin
            // Global freeze: nothing moves and the FSM holds its state.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else begin
            case (state)
                MDU_WAIT: begin
                    if (mdu_done) begin
                        state_nxt = RUN;
                    end else begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                    end
                end
                REDIRECT: begin
                    if (branch_taken) begin
                        pc_redirect = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        // Stale fill line is discarded, including on its last cycle.
                        if_id_flush = 1'b1;
                        pc_en       = !icache_stall;
                        if (!icache_stall)
                            state_nxt = RUN;
                    end
                end
                default: begin
                    if (branch_taken) begin
                        pc_redirect = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (icache_stall)
                            state_nxt = REDIRECT;
                    end else if (mdu_start && !mdu_done) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        state_nxt    = MDU_WAIT;
                    end else if (load_use_hazard) begin
                        pc_en              = 1'b0;
                        if_id_en           = 1'b0;
                        id_ex_hazard_stall = 1'b1;
                    end else if (icache_stall) begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            mdu_cnt     <= '0;
            mdu_timeout <= 1'b0;
        end else if (!dcache_stall) begin
            state <= state_nxt;
            if (state_nxt != MDU_WAIT) begin
                mdu_cnt <= '0;
            end else if (state == MDU_WAIT && mdu_cnt != CNT_W'(MDU_MAX_CYCLES)) begin
                // Counter saturates at the limit; the timeout flag is sticky.
                mdu_cnt <= mdu_cnt + 1'b1;
                if (mdu_cnt == CNT_W'(MDU_MAX_CYCLES - 1))
                    mdu_timeout <= 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en)
                stall_cycles <= stall_cycles + 1'b1;
            if (pc_redirect)
                flush_events <= flush_events + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; a second instance with a short MDU limit covers the timeout.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic icache_stall, dcache_stall, load_use_hazard, branch_taken, mdu_start, mdu_done;

    logic pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic id_ex_hazard_stall, ex_mem_en, ex_mem_flush, mem_wb_en, mdu_timeout;
    logic [31:0] stall_cycles, flush_events;

    logic t_pc_en, t_pc_redirect, t_if_id_en, t_if_id_flush, t_id_ex_en, t_id_ex_flush;
    logic t_id_ex_hazard_stall, t_ex_mem_en, t_ex_mem_flush, t_mem_wb_en, t_mdu_timeout;
    logic [31:0] t_stall_cycles, t_flush_events;

    int n_chk = 0;
    int n_err = 0;

    // {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //  id_ex_hazard_stall, ex_mem_en, ex_mem_flush, mem_wb_en}
    localparam logic [9:0] ALL0   = 10'b0_0_0_0_0_0_0_0_0_0;
    localparam logic [9:0] DEF    = 10'b1_0_1_0_1_0_0_1_0_1;
    localparam logic [9:0] LU     = 10'b0_0_0_0_1_0_1_1_0_1;
    localparam logic [9:0] BR     = 10'b1_1_1_1_1_1_0_1_0_1;
    localparam logic [9:0] ISTALL = 10'b0_0_1_1_1_0_0_1_0_1;
    localparam logic [9:0] RREL   = 10'b1_0_1_1_1_0_0_1_0_1;
    localparam logic [9:0] MW     = 10'b0_0_0_0_0_0_0_1_1_1;

    wire [9:0] ctl = {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                      id_ex_hazard_stall, ex_mem_en, ex_mem_flush, mem_wb_en};

    always #5 clk = ~clk;

    pipeline_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .mdu_start(mdu_start), .mdu_done(mdu_done),
        .pc_en(pc_en), .pc_redirect(pc_redirect), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .id_ex_hazard_stall(id_ex_hazard_stall),
        .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush), .mem_wb_en(mem_wb_en),
        .mdu_timeout(mdu_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    pipeline_ctrl #(.MDU_MAX_CYCLES(4)) u_short (
        .clk(clk), .rst_n(rst_n), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .mdu_start(mdu_start), .mdu_done(mdu_done),
        .pc_en(t_pc_en), .pc_redirect(t_pc_redirect), .if_id_en(t_if_id_en),
        .if_id_flush(t_if_id_flush), .id_ex_en(t_id_ex_en), .id_ex_flush(t_id_ex_flush),
        .id_ex_hazard_stall(t_id_ex_hazard_stall), .ex_mem_en(t_ex_mem_en),
        .ex_mem_flush(t_ex_mem_flush), .mem_wb_en(t_mem_wb_en),
        .mdu_timeout(t_mdu_timeout), .stall_cycles(t_stall_cycles), .flush_events(t_flush_events)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at the falling edge, let outputs settle, caller checks.
    task automatic cyc(input logic rn, input logic ic, input logic dc, input logic lu,
                       input logic br, input logic ms, input logic md);
        @(negedge clk);
        rst_n = rn; icache_stall = ic; dcache_stall = dc; load_use_hazard = lu;
        branch_taken = br; mdu_start = ms; mdu_done = md;
        #1;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; icache_stall = 0; dcache_stall = 0; load_use_hazard = 0;
        branch_taken = 0; mdu_start = 0; mdu_done = 0;

        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("reset_ctl", 32'(ctl), 32'(ALL0));
        cyc(0, 1, 0, 1, 1, 1, 0);
        chk("reset_ctl_inputs", 32'(ctl), 32'(ALL0));
        idle();
        chk("reset_timeout", 32'(mdu_timeout), 0);
        chk("idle_default", 32'(ctl), 32'(DEF));

        // Load-use: one bubble, then defaults
        cyc(1, 0, 0, 1, 0, 0, 0);
        chk("load_use", 32'(ctl), 32'(LU));
        idle();
        chk("load_use_after", 32'(ctl), 32'(DEF));

        // Branch with I-cache miss in flight
        cyc(1, 1, 0, 0, 1, 0, 0);
        chk("br_miss_t0", 32'(ctl), 32'(BR));
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 1, 0, 0, 0, 0, 0);
            chk($sformatf("br_miss_t%0d", i), 32'(ctl), 32'(ISTALL));
        end
        idle();
        chk("br_miss_t4", 32'(ctl), 32'(RREL));
        idle();
        chk("br_miss_t5_run", 32'(ctl), 32'(DEF));

        // Branch without miss stays in RUN; load-use ignored on the branch cycle
        cyc(1, 0, 0, 1, 1, 0, 0);
        chk("br_hit_lu", 32'(ctl), 32'(BR));
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("icache_stall_run", 32'(ctl), 32'(ISTALL));

        // MDU 5-cycle divide
        cyc(1, 0, 0, 0, 0, 1, 0);
        chk("mdu_t0", 32'(ctl), 32'(MW));
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 0, 0, 1, 1, 0, 0);
            chk($sformatf("mdu_t%0d", i), 32'(ctl), 32'(MW));
        end
        cyc(1, 0, 0, 0, 0, 0, 1);
        chk("mdu_t5_done", 32'(ctl), 32'(DEF));
        idle();
        chk("mdu_t6_run", 32'(ctl), 32'(DEF));
        chk("mdu_no_timeout", 32'(mdu_timeout), 0);

        // Single-cycle MDU op
        cyc(1, 0, 0, 0, 0, 1, 1);
        chk("mdu_single", 32'(ctl), 32'(DEF));
        idle();
        chk("mdu_single_after", 32'(ctl), 32'(DEF));

        // D-cache freeze over a branch
        cyc(1, 0, 1, 0, 1, 0, 0);
        chk("freeze_t0", 32'(ctl), 32'(ALL0));
        cyc(1, 0, 1, 0, 1, 0, 0);
        chk("freeze_t1", 32'(ctl), 32'(ALL0));
        cyc(1, 0, 0, 0, 1, 0, 0);
        chk("freeze_release_br", 32'(ctl), 32'(BR));
        idle();
        chk("freeze_after", 32'(ctl), 32'(DEF));

        // MDU timeout on the short-limit instance
        cyc(0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("to_reset_clear", 32'(t_mdu_timeout), 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) idle();
        chk("to_before", 32'(t_mdu_timeout), 0);
        idle();
        chk("to_set", 32'(t_mdu_timeout), 1);
        chk("to_still_wait", 32'({t_pc_en, t_if_id_en, t_id_ex_en, t_ex_mem_flush}), 32'(4'b0001));
        cyc(1, 0, 0, 0, 0, 0, 1);
        idle();
        chk("to_sticky", 32'(t_mdu_timeout), 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("to_reset_ctl", 32'({t_pc_en, t_mem_wb_en}), 0);
        idle();
        chk("to_cleared", 32'(t_mdu_timeout), 0);

        // Reset in the middle of an MDU wait
        cyc(1, 0, 0, 0, 0, 1, 0);
        idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rst_mid_ctl", 32'(ctl), 32'(ALL0));
        idle();
        chk("rst_mid_run", 32'(ctl), 32'(DEF));
        chk("perf_stall_zero", stall_cycles, 0);
        chk("perf_flush_zero", flush_events, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        idle();
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_3", stall_cycles, 3);
        chk("perf_flush_1", flush_events, 1);
`else
        chk("perf_stall_off", stall_cycles, 0);
        chk("perf_flush_off", flush_events, 0);
`endif
        chk("final_default", 32'(ctl), 32'(DEF));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
